gesture_servo_ctrl: RTL and testbench

Parametrised gesture-to-servo controller: maps a gesture code to per-channel servo pulse widths through a run-time programmable gesture table, and drives NUM_CH servo PWM outputs from one shared frame timebase. An optional per-frame slew limiter ramps each channel toward its target. Sits between the gesture classifier and the servo pins, and replaces fixed per-gesture width decoding plus separate per-servo PWM instances.

---
 rtl/gesture_servo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_gesture_servo_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_servo_ctrl.sv
// gesture_servo_ctrl: maps a gesture code to per-channel servo pulse widths
// through a run-time programmable table and drives NUM_CH servo PWM outputs
// from one shared frame timebase.
// Build option: define GESTURE_SERVO_RAMP_EN to compile in the per-frame slew
// limiter (STEP_US per frame); otherwise widths jump to target at frame start.
module gesture_servo_ctrl #(
  parameter int unsigned NUM_CH    = 5,
  parameter int unsigned GESTURE_W = 8,
  parameter int unsigned NUM_GEST  = 16,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned FRAME_US  = 20000,
  parameter int unsigned W_MIN     = 1000,
  parameter int unsigned W_MAX     = 2000,
  parameter int unsigned W_RESET   = 1500,
  parameter int unsigned STEP_US   = 20,
  localparam int unsigned AW = (NUM_GEST > 1) ? $clog2(NUM_GEST) : 1,
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [GESTURE_W-1:0]   gesture,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [15:0]            cfg_width,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic [16*NUM_CH-1:0]   width_out,
  output logic                   frame_tick,
  output logic                   busy
);

  localparam int unsigned DIV  = CLK_HZ / 1_000_000;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned UW   = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int unsigned SPAN = W_MAX - W_MIN;
`ifdef GESTURE_SERVO_RAMP_EN
  localparam int unsigned STEP_EFF = STEP_US;
`else
  // A step covering the whole legal span makes every frame update a full jump.
  localparam int unsigned STEP_EFF = (SPAN > STEP_US) ? SPAN : STEP_US;
`endif
  localparam logic [15:0] STEP16 = 16'(STEP_EFF);
  localparam logic [15:0] WMIN16 = 16'(W_MIN);
  localparam logic [15:0] WMAX16 = 16'(W_MAX);
  localparam logic [15:0] WRST16 = 16'(W_RESET);

  logic [PW-1:0]     r_pre;
  logic [PW-1:0]     w_pre_nxt;
  logic [UW-1:0]     r_us;
  logic [UW-1:0]     w_us_nxt;
  logic              r_started;
  logic              w_started_nxt;
  logic              w_us_tick;
  logic              w_frame;

  logic [15:0]       r_tbl     [NUM_GEST][NUM_CH];
  logic [15:0]       r_tgt     [NUM_CH];
  logic [15:0]       w_tgt_nxt [NUM_CH];
  logic [15:0]       r_cur     [NUM_CH];
  logic [15:0]       w_cur_nxt [NUM_CH];

  logic [NUM_CH-1:0] w_pwm_nxt;
  logic              w_busy_nxt;
  logic              w_gest_ok;
  logic [AW-1:0]     w_gidx;
  logic              w_cfg_ok;
  logic [15:0]       w_cfg_clamped;

  // Decode gesture selection and clamp incoming table writes.
  always_comb begin
    w_gest_ok     = (gesture != '0) && (32'(gesture) <= NUM_GEST);
    w_gidx        = AW'(gesture - GESTURE_W'(1));
    w_cfg_ok      = (32'(cfg_addr) < NUM_GEST) && (32'(cfg_ch) < NUM_CH);
    w_cfg_clamped = cfg_width;
    if (cfg_width < WMIN16) begin
      w_cfg_clamped = WMIN16;
    end else if (cfg_width > WMAX16) begin
      w_cfg_clamped = WMAX16;
    end
  end

  // Prescaler, microsecond counter and frame-start detection.
  always_comb begin
    w_us_tick     = (r_pre == PW'(DIV - 1));
    w_pre_nxt     = w_us_tick ? '0 : r_pre + PW'(1);
    // The first tick after reset opens frame 0 without advancing us_cnt.
    w_frame       = w_us_tick && (!r_started || (r_us == UW'(FRAME_US - 1)));
    w_started_nxt = r_started | w_us_tick;
    w_us_nxt      = r_us;
    if (w_frame) begin
      w_us_nxt = '0;
    end else if (w_us_tick) begin
      w_us_nxt = r_us + UW'(1);
    end
  end

  // Target load, frame-aligned width update, PWM compare and busy.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_pwm_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_tgt_nxt[i] = r_tgt[i];
      w_cur_nxt[i] = r_cur[i];
      if (w_gest_ok) begin
        w_tgt_nxt[i] = r_tbl[w_gidx][i];
      end
      // Step toward the target held before this edge; no wrap in either direction.
      if (w_frame) begin
        if (r_tgt[i] > r_cur[i]) begin
          w_cur_nxt[i] = ((r_tgt[i] - r_cur[i]) > STEP16) ? r_cur[i] + STEP16 : r_tgt[i];
        end else begin
          w_cur_nxt[i] = ((r_cur[i] - r_tgt[i]) > STEP16) ? r_cur[i] - STEP16 : r_tgt[i];
        end
      end
      w_pwm_nxt[i] = w_started_nxt && (32'(w_us_nxt) < 32'(w_cur_nxt[i]));
      if (r_cur[i] != r_tgt[i]) begin
        w_busy_nxt = 1'b1;
      end
    end
  end

  // Timebase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= '0;
      r_us      <= '0;
      r_started <= 1'b0;
    end else begin
      r_pre     <= w_pre_nxt;
      r_us      <= w_us_nxt;
      r_started <= w_started_nxt;
    end
  end

  // Gesture table storage; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NUM_GEST; g++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_tbl[g][c] <= WRST16;
        end
      end
    end else if (cfg_we && w_cfg_ok) begin
      r_tbl[cfg_addr][cfg_ch] <= w_cfg_clamped;
    end
  end

  // Per-channel target and applied width registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_tgt[c] <= WRST16;
        r_cur[c] <= WRST16;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_tgt[c] <= w_tgt_nxt[c];
        r_cur[c] <= w_cur_nxt[c];
      end
    end
  end

  // Registered pin-level outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out    <= '0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pwm_out    <= w_pwm_nxt;
      frame_tick <= w_frame;
      busy       <= w_busy_nxt;
    end
  end

  // Applied widths exported straight from the width registers.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_width
    assign width_out[16*g +: 16] = r_cur[g];
  end

endmodule

// File: tb/tb_gesture_servo_ctrl.sv
// Self-checking bench for gesture_servo_ctrl with a shortened frame so the
// whole run stays small: 2 clocks per us, 300 us frames, widths 100..200 us.
module tb_gesture_servo_ctrl;

  localparam int unsigned NCH   = 5;
  localparam int unsigned GW    = 8;
  localparam int unsigned NG    = 16;
  localparam int unsigned CLKHZ = 2_000_000;
  localparam int unsigned FUS   = 300;
  localparam int unsigned WMIN  = 100;
  localparam int unsigned WMAX  = 200;
  localparam int unsigned WRST  = 150;
  localparam int unsigned STEP  = 20;
  localparam int unsigned DIV   = CLKHZ / 1_000_000;
  localparam int unsigned FCYC  = FUS * DIV;
  localparam int unsigned OW    = NCH + 2 + 16 * NCH;
`ifdef GESTURE_SERVO_RAMP_EN
  localparam int STEP_M = STEP;
`else
  localparam int STEP_M = 1 << 20;
`endif

  logic               clk;
  logic               reset;
  logic [GW-1:0]      gesture;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [2:0]         cfg_ch;
  logic [15:0]        cfg_width;
  logic [NCH-1:0]     pwm_out;
  logic [16*NCH-1:0]  width_out;
  logic               frame_tick;
  logic               busy;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers, advanced once per rising edge.
  int unsigned m_e;
  int          m_tbl [NG][NCH];
  int          m_tgt [NCH];
  int          m_cur [NCH];
  bit          m_ft;
  bit          m_busy;
  bit [NCH-1:0] m_pwm;

  gesture_servo_ctrl #(
    .NUM_CH(NCH), .GESTURE_W(GW), .NUM_GEST(NG), .CLK_HZ(CLKHZ),
    .FRAME_US(FUS), .W_MIN(WMIN), .W_MAX(WMAX), .W_RESET(WRST), .STEP_US(STEP)
  ) dut (
    .clk(clk), .reset(reset), .gesture(gesture), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_ch(cfg_ch), .cfg_width(cfg_width),
    .pwm_out(pwm_out), .width_out(width_out), .frame_tick(frame_tick), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampw(int w);
    if (w < int'(WMIN)) return int'(WMIN);
    if (w > int'(WMAX)) return int'(WMAX);
    return w;
  endfunction

  task automatic model_init();
    m_e = 0; m_ft = 0; m_busy = 0; m_pwm = '0;
    for (int g = 0; g < NG; g++)
      for (int c = 0; c < NCH; c++) m_tbl[g][c] = int'(WRST);
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = int'(WRST);
      m_cur[c] = int'(WRST);
    end
  endtask

  // Frame starts at edge DIV after release, then every FCYC edges.
  task automatic model_edge();
    int old_tgt [NCH];
    bit fs;
    int unsigned us;
    int d;
    if (!reset) begin
      model_init();
      return;
    end
    m_e++;
    fs = (m_e >= DIV) && (((m_e - DIV) % FCYC) == 0);
    m_busy = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (m_cur[c] != m_tgt[c]) m_busy = 1'b1;
      old_tgt[c] = m_tgt[c];
    end
    if (gesture >= 1 && int'(gesture) <= int'(NG))
      for (int c = 0; c < NCH; c++) m_tgt[c] = m_tbl[int'(gesture) - 1][c];
    if (cfg_we && int'(cfg_addr) < int'(NG) && int'(cfg_ch) < int'(NCH))
      m_tbl[cfg_addr][cfg_ch] = clampw(int'(cfg_width));
    if (fs) begin
      for (int c = 0; c < NCH; c++) begin
        d = old_tgt[c] - m_cur[c];
        if (d > STEP_M) m_cur[c] = m_cur[c] + STEP_M;
        else if (d < -STEP_M) m_cur[c] = m_cur[c] - STEP_M;
        else m_cur[c] = old_tgt[c];
      end
    end
    m_ft = fs;
    us = (m_e >= DIV) ? ((m_e - DIV) / DIV) % FUS : 0;
    for (int c = 0; c < NCH; c++) m_pwm[c] = (m_e >= DIV) && (int'(us) < m_cur[c]);
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [16*NCH-1:0] w;
    for (int c = 0; c < NCH; c++) w[16*c +: 16] = 16'(m_cur[c]);
    return {m_pwm, m_ft, m_busy, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [16*NCH-1:0] all_rst;
    int hi, gap, nft;
    for (int c = 0; c < NCH; c++) all_rst[16*c +: 16] = 16'(WRST);
    reset = 1'b0; gesture = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_ch = '0; cfg_width = '0;
    model_init();
    #22;
    checks++;
    if ({pwm_out, frame_tick, busy} !== '0) begin
      errors++; $display("FAIL reset_ctl got=%b exp=0", {pwm_out, frame_tick, busy});
    end
    checks++;
    if (width_out !== all_rst) begin
      errors++; $display("FAIL reset_width got=%h exp=%h", width_out, all_rst);
    end
    @(negedge clk);
    reset = 1'b1;
    hi = 0; gap = 0; nft = 0;
    for (int n = 0; n < 2 * FCYC + 10; n++) begin
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL reset_run e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
      if (frame_tick === 1'b1) begin
        if (nft > 0) begin
          checks++;
          if (hi !== int'(WRST * DIV) || gap !== int'(FCYC)) begin
            errors++; $display("FAIL reset_frame hi=%0d gap=%0d exp_hi=%0d exp_gap=%0d", hi, gap, WRST * DIV, FCYC);
          end
        end
        nft++; hi = 0; gap = 0;
      end
      gap++;
      if (pwm_out[0] === 1'b1) hi++;
    end
    checks++;
    if (nft !== 3) begin
      errors++; $display("FAIL reset_ntick got=%0d exp=3", nft);
    end
  endtask

  task automatic test_ramp();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_ch = 3'd2; cfg_width = 16'(WMIN);
    tick();
    cfg_we = 1'b0; gesture = 8'd1;
    for (int n = 0; n < 5 * FCYC; n++) begin
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL ramp e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
    end
    checks++;
    if (width_out[47:32] !== 16'(WMIN) || width_out[15:0] !== 16'(WRST) || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_final ch2=%0d ch0=%0d busy=%b exp=%0d/%0d/0", width_out[47:32], width_out[15:0], busy, WMIN, WRST);
    end
  endtask

  task automatic test_clamp();
    cfg_we = 1'b1; cfg_addr = 4'd3;
    cfg_ch = 3'd0; cfg_width = 16'd250; tick();
    cfg_ch = 3'd1; cfg_width = 16'd50;  tick();
    cfg_ch = 3'd5; cfg_width = 16'd180; tick();
    cfg_ch = 3'd7; cfg_width = 16'd120; tick();
    cfg_we = 1'b0; gesture = 8'd4;
    for (int n = 0; n < 4 * FCYC; n++) begin
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL clamp e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
    end
    checks++;
    if (width_out[15:0] !== 16'(WMAX) || width_out[31:16] !== 16'(WMIN) || width_out[47:32] !== 16'(WRST)) begin
      errors++; $display("FAIL clamp_final ch0=%0d ch1=%0d ch2=%0d exp=%0d/%0d/%0d", width_out[15:0], width_out[31:16], width_out[47:32], WMAX, WMIN, WRST);
    end
  endtask

  task automatic test_hold();
    logic [GW-1:0] codes [3];
    codes[0] = 8'd0; codes[1] = 8'd17; codes[2] = 8'd255;
    for (int k = 0; k < 3; k++) begin
      gesture = codes[k];
      for (int n = 0; n < FCYC + 7; n++) begin
        tick();
        checks++;
        if ({pwm_out, frame_tick, busy, width_out} !== exp_vec() || busy !== 1'b0) begin
          errors++; $display("FAIL hold g=%0d e=%0d got=%h exp=%h", codes[k], m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
        end
      end
    end
    checks++;
    if (width_out[15:0] !== 16'(WMAX) || width_out[31:16] !== 16'(WMIN)) begin
      errors++; $display("FAIL hold_final ch0=%0d ch1=%0d exp=%0d/%0d", width_out[15:0], width_out[31:16], WMAX, WMIN);
    end
  endtask

  task automatic test_back_to_back();
    // Write and load of the same entry in one cycle, then gesture flips near frame starts.
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_ch = 3'd0; cfg_width = 16'd120; gesture = 8'd4;
    tick();
    cfg_we = 1'b0;
    for (int n = 0; n < 3 * FCYC; n++) begin
      if ((m_e % FCYC) == DIV - 1) gesture = (gesture == 8'd4) ? 8'd1 : 8'd4;
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL b2b e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) gesture = GW'($urandom_range(0, 20));
      cfg_we    = ($urandom_range(0, 29) == 0);
      cfg_addr  = 4'($urandom_range(0, 15));
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_width = 16'($urandom_range(0, 300));
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL random e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [16*NCH-1:0] all_rst;
    for (int c = 0; c < NCH; c++) all_rst[16*c +: 16] = 16'(WRST);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_ch = 3'd2; cfg_width = 16'(WMAX); gesture = 8'd1;
    tick();
    cfg_we = 1'b0;
    for (int n = 0; n < 6 * FCYC; n++) tick();
    cfg_we = 1'b1; cfg_width = 16'(WMIN);
    tick();
    cfg_we = 1'b0;
    while ((m_e % FCYC) != DIV + 40) tick();
    checks++;
    if (pwm_out[2] !== 1'b1 || busy !== m_busy) begin
      errors++; $display("FAIL premid pwm2=%b busy=%b exp=1/%b", pwm_out[2], busy, m_busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({pwm_out, frame_tick, busy} !== '0 || width_out !== all_rst) begin
      errors++; $display("FAIL mid_reset ctl=%b width=%h exp=0/%h", {pwm_out, frame_tick, busy}, width_out, all_rst);
    end
    model_init();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 2 * FCYC; n++) begin
      tick();
      checks++;
      if ({pwm_out, frame_tick, busy, width_out} !== exp_vec()) begin
        errors++; $display("FAIL post_reset e=%0d got=%h exp=%h", m_e, {pwm_out, frame_tick, busy, width_out}, exp_vec());
      end
    end
    checks++;
    if (width_out !== all_rst || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_final width=%h busy=%b exp=%h/0", width_out, busy, all_rst);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
